// File: rtl/muu_repeater_sched_pkg.sv
// Shared types for the repeater scheduler.
// FSM state encoding, config word type, grant index width.
package muu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef logic [7:0] cnt_t;

  localparam int GID_W = 3;

endpackage

// File: rtl/muu_repeater_sched_arbiter.sv
// Combinational round-robin pick over N requests.
// Lowest distance from ptr (with wrap) wins; pointer register lives in the top.
module muu_rr_arbiter
  import muu_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [GID_W-1:0] gnt_idx,
  output logic             any
);

  int w_best;
  int w_dist;

  // Pick the requester closest to ptr going upward.
  always_comb begin
    w_best  = N;
    w_dist  = 0;
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(ptr)) % N;
      if (req[j] && w_dist < w_best) begin
        w_best  = w_dist;
        gnt_idx = GID_W'(j);
      end
    end
    any = (w_best < N);
  end

  // Expand the winning index to a one-hot vector.
  always_comb begin
    gnt_onehot = '0;
    for (int j = 0; j < N; j++) begin
      gnt_onehot[j] = any && (gnt_idx == GID_W'(j));
    end
  end

endmodule

// File: rtl/muu_repeater_sched.sv
// Round-robin job scheduler in front of one shared data repeater.
// Optional job legality check: define MUU_REPSCHED_CFGCHK_EN.
module muu_repeater_sched
  import muu_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int DATA_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*NUM_REQ-1:0]          req_config_count,
  input  logic [8*NUM_REQ-1:0]          req_config_size,
  input  logic [NUM_REQ-1:0]            req_config_valid,
  output logic [NUM_REQ-1:0]            req_config_ready,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_axis_tdata,
  input  logic [NUM_REQ-1:0]            req_axis_tvalid,
  output logic [NUM_REQ-1:0]            req_axis_tready,
  output logic [7:0]                    rep_config_count,
  output logic [7:0]                    rep_config_size,
  output logic                          rep_config_valid,
  input  logic                          rep_config_ready,
  output logic [DATA_WIDTH-1:0]         rep_axis_tdata,
  output logic                          rep_axis_tvalid,
  input  logic                          rep_axis_tready,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          cfg_err
);

  state_t           r_state;
  logic [GID_W-1:0] r_ptr;
  logic [GID_W-1:0] r_gid;
  cnt_t             r_cnt;
  cnt_t             r_size;
  cnt_t             r_left;

  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [GID_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic [GID_W-1:0]      w_ptr_nxt;
  cnt_t                  w_cnt;
  cnt_t                  w_size;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic                  w_tvalid;
  logic                  w_take;
  logic                  w_bad;
  logic                  w_data_hs;

  muu_rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req       (req_config_valid),
    .ptr       (r_ptr),
    .gnt_onehot(w_gnt_oh),
    .gnt_idx   (w_gnt_idx),
    .any       (w_any)
  );

  // Mux the winner's config and the granted requester's data stream.
  always_comb begin
    w_cnt    = '0;
    w_size   = '0;
    w_tdata  = '0;
    w_tvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GID_W'(i) == w_gnt_idx) begin
        w_cnt  = req_config_count[8*i +: 8];
        w_size = req_config_size[8*i +: 8];
      end
      if (GID_W'(i) == r_gid) begin
        w_tdata  = req_axis_tdata[DATA_WIDTH*i +: DATA_WIDTH];
        w_tvalid = req_axis_tvalid[i];
      end
    end
  end

`ifdef MUU_REPSCHED_CFGCHK_EN
  assign w_bad = (w_cnt == 8'd0) || (w_size == 8'd0) ||
                 (int'(w_size) > DATA_DEPTH);
`else
  assign w_bad = 1'b0;
`endif

  assign w_take    = (r_state == S_IDLE) && w_any;
  assign w_data_hs = (r_state == S_DATA) && w_tvalid && rep_axis_tready;
  assign w_ptr_nxt = (w_gnt_idx == GID_W'(NUM_REQ - 1)) ?
                     '0 : w_gnt_idx + 1'b1;

  // Job FSM: grant, issue config, then stream size words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_left  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ptr <= w_ptr_nxt;
            if (!w_bad) begin
              r_state <= S_CFG;
              r_gid   <= w_gnt_idx;
              r_cnt   <= w_cnt;
              r_size  <= w_size;
              r_left  <= w_size;
            end
          end
        end
        S_CFG: begin
          if (rep_config_ready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_data_hs) begin
            r_left <= r_left - 8'd1;
            if (r_left == 8'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MUU_REPSCHED_CFGCHK_EN
  logic r_err;

  // Sticky flag for a dropped illegal job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (w_take && w_bad) r_err <= 1'b1;
  end

  assign cfg_err = r_err;
`else
  assign cfg_err = 1'b0;
`endif

  // Only the granted requester ever sees tready, and only in DATA.
  always_comb begin
    req_axis_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_axis_tready[i] = (r_state == S_DATA) &&
                           (GID_W'(i) == r_gid) && rep_axis_tready;
    end
  end

  assign req_config_ready = w_take ? w_gnt_oh : '0;
  assign rep_config_count = r_cnt;
  assign rep_config_size  = r_size;
  assign rep_config_valid = (r_state == S_CFG);
  assign rep_axis_tdata   = w_tdata;
  assign rep_axis_tvalid  = (r_state == S_DATA) && w_tvalid;
  assign grant_id         = r_gid;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_muu_repeater_sched.sv
// Directed bench for muu_repeater_sched.
// Covers reset, round-robin, back-pressure, gaps, mid-job reset, config check.
module tb_muu_repeater_sched;

  localparam int NR = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [8*NR-1:0]  req_config_count;
  logic [8*NR-1:0]  req_config_size;
  logic [NR-1:0]    req_config_valid;
  logic [NR-1:0]    req_config_ready;
  logic [DW*NR-1:0] req_axis_tdata;
  logic [NR-1:0]    req_axis_tvalid;
  logic [NR-1:0]    req_axis_tready;
  logic [7:0]       rep_config_count;
  logic [7:0]       rep_config_size;
  logic             rep_config_valid;
  logic             rep_config_ready;
  logic [DW-1:0]    rep_axis_tdata;
  logic             rep_axis_tvalid;
  logic             rep_axis_tready;
  logic [2:0]       grant_id;
  logic             busy;
  logic             cfg_err;

  int n_chk = 0;
  int n_err = 0;

  muu_repeater_sched #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .DATA_DEPTH(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_config_count(req_config_count),
    .req_config_size (req_config_size),
    .req_config_valid(req_config_valid),
    .req_config_ready(req_config_ready),
    .req_axis_tdata  (req_axis_tdata),
    .req_axis_tvalid (req_axis_tvalid),
    .req_axis_tready (req_axis_tready),
    .rep_config_count(rep_config_count),
    .rep_config_size (rep_config_size),
    .rep_config_valid(rep_config_valid),
    .rep_config_ready(rep_config_ready),
    .rep_axis_tdata  (rep_axis_tdata),
    .rep_axis_tvalid (rep_axis_tvalid),
    .rep_axis_tready (rep_axis_tready),
    .grant_id        (grant_id),
    .busy            (busy),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int r, input int c, input int s);
    req_config_count[8*r +: 8] = 8'(c);
    req_config_size[8*r +: 8]  = 8'(s);
    req_config_valid[r]        = 1'b1;
    #1;
    chk("cfg_rdy", 64'(req_config_ready), 64'd1 << r);
    chk("busy_idle", 64'(busy), 0);
    tick();
    req_config_valid[r] = 1'b0;
    #1;
    chk("rep_cfg_v", 64'(rep_config_valid), 1);
    chk("rep_cfg_cnt", 64'(rep_config_count), 64'(c));
    chk("rep_cfg_size", 64'(rep_config_size), 64'(s));
    chk("gid", 64'(grant_id), 64'(r));
    chk("trdy_cfg", 64'(req_axis_tready), 0);
    chk("tvalid_cfg", 64'(rep_axis_tvalid), 0);
  endtask

  task automatic cfg_accept(input int c, input int s, input int w);
    for (int i = 0; i < w; i++) begin
      tick();
      #1;
      chk("cfg_hold_v", 64'(rep_config_valid), 1);
      chk("cfg_hold_cnt", 64'(rep_config_count), 64'(c));
      chk("cfg_hold_size", 64'(rep_config_size), 64'(s));
      chk("cfg_hold_trdy", 64'(req_axis_tready), 0);
    end
    rep_config_ready = 1'b1;
    tick();
    rep_config_ready = 1'b0;
  endtask

  task automatic stream(input int r, input int s, input int stop,
                        input logic [15:0] base, input bit tog,
                        input int gap_at, input int gap_len);
    int k = 0;
    int g = 0;
    int budget = 0;
    bit ph = 1'b0;
    while (k < stop && budget < 300) begin
      req_axis_tdata[DW*r +: DW] = base + 16'(k);
      req_axis_tvalid[r] = !(k == gap_at && g < gap_len);
      rep_axis_tready = tog ? ph : 1'b1;
      ph = !ph;
      #1;
      chk("ng_trdy", 64'(req_axis_tready) & ~(64'd1 << r), 0);
      chk("busy_data", 64'(busy), 1);
      if (req_axis_tvalid[r] && rep_axis_tready) begin
        chk("fwd_v", 64'(rep_axis_tvalid), 1);
        chk("fwd_d", 64'(rep_axis_tdata), 64'(base + 16'(k)));
        chk("g_trdy", 64'(req_axis_tready), 64'd1 << r);
        k++;
      end else if (!req_axis_tvalid[r]) begin
        chk("gap_v", 64'(rep_axis_tvalid), 0);
        g++;
      end
      budget++;
      tick();
    end
    if (budget >= 300) chk("timeout", 0, 1);
    if (stop == s) begin
      req_axis_tvalid[r] = 1'b0;
      rep_axis_tready    = 1'b0;
      #1;
      chk("idle_after", 64'(busy), 0);
      chk("gid_hold", 64'(grant_id), 64'(r));
      chk("tvalid_idle", 64'(rep_axis_tvalid), 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    req_config_count = '0;
    req_config_size  = '0;
    req_config_valid = '0;
    req_axis_tdata   = '0;
    req_axis_tvalid  = '0;
    rep_config_ready = 1'b0;
    rep_axis_tready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_gid", 64'(grant_id), 0);
    chk("rst_cfg_v", 64'(rep_config_valid), 0);
    chk("rst_cfg_cnt", 64'(rep_config_count), 0);
    chk("rst_err", 64'(cfg_err), 0);
    rst = 1'b1;

    // all four valid at once, size 1 each
    for (int e = 0; e < NR; e++) begin
      req_config_count[8*e +: 8] = 8'd1;
      req_config_size[8*e +: 8]  = 8'd1;
    end
    req_config_valid = 4'hF;
    for (int e = 0; e < NR; e++) begin
      #1;
      chk("rr_rdy", 64'(req_config_ready), 64'd1 << e);
      tick();
      req_config_valid[e] = 1'b0;
      #1;
      chk("rr_gid", 64'(grant_id), 64'(e));
      cfg_accept(1, 1, 0);
      stream(e, 1, 1, 16'(16'h0100 + e * 16), 1'b0, 0, 0);
    end

    // single job on req0, re-raised after the round
    grant(0, 3, 4);
    cfg_accept(3, 4, 0);
    stream(0, 4, 4, 16'h00A0, 1'b0, 0, 0);

    // config held off 10 cycles, data ready toggling
    grant(1, 2, 3);
    cfg_accept(2, 3, 10);
    stream(1, 3, 3, 16'h1100, 1'b1, 0, 0);

    // tvalid gap of 5 cycles before word 2
    grant(3, 5, 4);
    cfg_accept(5, 4, 1);
    stream(3, 4, 4, 16'h3300, 1'b0, 2, 5);

    // reset after 2 of 4 words
    grant(2, 1, 4);
    cfg_accept(1, 4, 0);
    stream(2, 4, 2, 16'h2200, 1'b0, 0, 0);
    req_axis_tvalid[2] = 1'b1;
    rep_axis_tready    = 1'b1;
    #1;
    chk("mid_before_rst", 64'(req_axis_tready), 64'd4);
    rst = 1'b0;
    #1;
    chk("mrst_trdy", 64'(req_axis_tready), 0);
    chk("mrst_tvalid", 64'(rep_axis_tvalid), 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_gid", 64'(grant_id), 0);
    chk("mrst_cfg_v", 64'(rep_config_valid), 0);
    chk("mrst_cfg_rdy", 64'(req_config_ready), 0);
    tick();
    req_axis_tvalid = '0;
    rep_axis_tready = 1'b0;
    rst = 1'b1;
    grant(2, 2, 2);
    cfg_accept(2, 2, 0);
    stream(2, 2, 2, 16'h2A00, 1'b0, 0, 0);

`ifdef MUU_REPSCHED_CFGCHK_EN
    req_config_count[8*1 +: 8] = 8'd2;
    req_config_size[8*1 +: 8]  = 8'd0;
    req_config_valid[1] = 1'b1;
    #1;
    chk("bad0_rdy", 64'(req_config_ready), 64'd2);
    tick();
    req_config_valid[1] = 1'b0;
    #1;
    chk("bad0_busy", 64'(busy), 0);
    chk("bad0_cfg_v", 64'(rep_config_valid), 0);
    chk("bad0_err", 64'(cfg_err), 1);
    req_config_count[8*2 +: 8] = 8'd1;
    req_config_size[8*2 +: 8]  = 8'd17;
    req_config_valid[2] = 1'b1;
    #1;
    chk("bad17_rdy", 64'(req_config_ready), 64'd4);
    tick();
    req_config_valid[2] = 1'b0;
    #1;
    chk("bad17_busy", 64'(busy), 0);
    chk("bad17_cfg_v", 64'(rep_config_valid), 0);
    grant(3, 1, 2);
    cfg_accept(1, 2, 0);
    stream(3, 2, 2, 16'h3A00, 1'b0, 0, 0);
    chk("err_sticky", 64'(cfg_err), 1);
`else
    chk("err_tied", 64'(cfg_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
